// File: rtl/cpu_types.sv
// rtl/cpu_types.sv - shared fetch types: state encoding and prefetch queue entry
package cpu_types;

   localparam int CPU_XLEN = 32;

   typedef enum logic [1:0] {
      FS_BOOT,
      FS_RUN,
      FS_HALT
   } fetch_state_t;

   typedef struct packed {
      logic [31:0]          insn;
      logic [CPU_XLEN-1:0]  pc;
      logic                 err;
   } fetch_entry_t;

endpackage

// File: rtl/cpu_fetch_unit_fifo.sv
// rtl/cpu_fetch_unit_fifo.sv - synchronous FIFO with flush; pop and push allowed together when full
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop & ~empty;
   // a pop frees the slot the same cycle, so a full queue still accepts a push
   assign do_push = push & (~full | do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_inc(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
         if (do_push && !do_pop)
            count <= count + CW'(1);
         else if (!do_push && do_pop)
            count <= count - CW'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

   a_no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(push && full && !pop && !flush));

endmodule

// File: rtl/cpu_fetch_unit.sv
// rtl/cpu_fetch_unit.sv - pipelined instruction fetch front end with prefetch queue
module cpu_fetch_unit
   import cpu_types::*;
#(
   parameter int              XLEN            = CPU_XLEN,
   parameter int              DEPTH           = 4,
   parameter int              MAX_OUTSTANDING = 2,
   parameter logic [XLEN-1:0] RESET_PC        = '0
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_halt,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_pc,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_gnt,
   input  logic            i_imem_rvalid,
   input  logic [31:0]     i_imem_rdata,
   input  logic            i_imem_err,
   output logic            o_insn_valid,
   output logic [31:0]     o_insn,
   output logic [XLEN-1:0] o_insn_pc,
   output logic            o_insn_err,
   input  logic            i_insn_ready
);

   localparam int OW = $clog2(MAX_OUTSTANDING + 1);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = CW + 1;
   localparam int QW = $bits(fetch_entry_t);

   fetch_state_t    state;
   fetch_state_t    state_nxt;
   logic [XLEN-1:0] fetch_pc;
   logic [OW-1:0]   outstanding;
   logic [OW-1:0]   discard;
   logic [CW-1:0]   occupancy;
   logic [SW-1:0]   credit_used;
   logic            issue;
   logic            fire;
   logic            resp;
   logic            q_push;
   logic            q_pop;
   logic            q_full;
   logic            q_empty;
   logic            tag_full;
   logic            tag_empty;
   logic [XLEN-1:0] tag_pc;
   fetch_entry_t    q_in;
   fetch_entry_t    q_head;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= FS_BOOT;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         FS_BOOT: state_nxt = i_halt ? FS_HALT : FS_RUN;
         FS_RUN:  if (i_halt)  state_nxt = FS_HALT;
         FS_HALT: if (!i_halt) state_nxt = FS_RUN;
         default: state_nxt = FS_BOOT;
      endcase
   end

   // credit counts both queued and in-flight words so a response always finds room
   assign credit_used = SW'(occupancy) + SW'(outstanding);

   always_comb begin
      issue = 1'b0;
      if (state == FS_RUN && !i_halt && !i_redirect && !tag_full && !q_full
          && credit_used < SW'(DEPTH))
         issue = 1'b1;
   end

   assign o_imem_req  = issue;
   assign o_imem_addr = fetch_pc;
   assign fire        = issue & i_imem_gnt;
   assign resp        = i_imem_rvalid & ~tag_empty;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         fetch_pc <= RESET_PC;
      else if (i_redirect)
         fetch_pc <= {i_redirect_pc[XLEN-1:2], 2'b00};
      else if (fire)
         fetch_pc <= fetch_pc + XLEN'(4);
   end

   // every fetch still in flight at a redirect belongs to the old stream
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         discard <= '0;
      else if (i_redirect)
         discard <= outstanding - OW'(resp);
      else if (resp && discard != '0)
         discard <= discard - OW'(1);
   end

   assign q_push  = resp & (discard == '0) & ~i_redirect;
   assign q_pop   = ~q_empty & i_insn_ready & ~i_redirect;
   assign q_in.insn = i_imem_err ? 32'h0 : i_imem_rdata;
   assign q_in.pc   = tag_pc;
   assign q_in.err  = i_imem_err;

   sync_fifo #(
      .WIDTH (XLEN),
      .DEPTH (MAX_OUTSTANDING)
   ) u_tag_fifo (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .flush     (1'b0),
      .push      (fire),
      .push_data (fetch_pc),
      .pop       (resp),
      .pop_data  (tag_pc),
      .full      (tag_full),
      .empty     (tag_empty),
      .count     (outstanding)
   );

   sync_fifo #(
      .WIDTH (QW),
      .DEPTH (DEPTH)
   ) u_prefetch_q (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .flush     (i_redirect),
      .push      (q_push),
      .push_data (q_in),
      .pop       (q_pop),
      .pop_data  (q_head),
      .full      (q_full),
      .empty     (q_empty),
      .count     (occupancy)
   );

   assign o_insn_valid = ~q_empty;
   assign o_insn       = q_empty ? 32'h0 : q_head.insn;
   assign o_insn_pc    = q_empty ? '0    : q_head.pc;
   assign o_insn_err   = q_empty ? 1'b0  : q_head.err;

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// tb/tb_cpu_fetch_unit.sv - self-checking bench for cpu_fetch_unit
module tb_cpu_fetch_unit;

   localparam int MAXO = 2;

   logic        clk = 1'b0;
   logic        rst_n, halt, redirect, gnt, rvalid, err, ready;
   logic [31:0] redirect_pc, rdata;
   logic        req, valid, ierr;
   logic [31:0] addr, insn, ipc;

   always #5 clk = ~clk;

   cpu_fetch_unit dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_halt(halt), .i_redirect(redirect),
      .i_redirect_pc(redirect_pc), .o_imem_req(req), .o_imem_addr(addr),
      .i_imem_gnt(gnt), .i_imem_rvalid(rvalid), .i_imem_rdata(rdata),
      .i_imem_err(err), .o_insn_valid(valid), .o_insn(insn), .o_insn_pc(ipc),
      .o_insn_err(ierr), .i_insn_ready(ready)
   );

   typedef struct { logic [31:0] a; int due; } mreq_t;
   typedef struct { logic rdy; logic req; logic [31:0] addr; logic v; logic [31:0] pc; } vec_t;

   mreq_t       mq[$];
   vec_t        tbl[15];
   int          total = 0, bad = 0;
   int          cyc, gnt_pct, lat_lo, lat_hi, fault_mode, npop, err_pops, ngrant;
   logic [31:0] exp_pc, last_pop_pc, first_req_addr;
   bit          halt_prev, got_req;

   function automatic logic [31:0] img(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   function automatic bit is_fault(input logic [31:0] a);
      if (fault_mode == 1) return a == 32'h8;
      if (fault_mode == 2) return a[6:2] == 5'd7;
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // memory model drives inputs; scoreboard observes handshakes before the edge
   task automatic drive_sample();
      int lat;
      gnt = ($urandom_range(99) < gnt_pct);
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         rvalid = 1'b1; err = is_fault(mq[0].a); rdata = img(mq[0].a);
      end else begin
         rvalid = 1'b0; err = 1'($urandom_range(1)); rdata = $urandom;
      end
      #1;
      if (rvalid) void'(mq.pop_front());
      if (req && gnt) begin
         lat = $urandom_range(lat_hi, lat_lo);
         mq.push_back('{addr, cyc + lat});
         chk("outstanding_le_max", 32'(mq.size() <= MAXO), 1);
         chk("req_addr_aligned", 32'(addr[1:0]), 0);
      end
      if (req && !got_req) begin got_req = 1; first_req_addr = addr; end
      if (halt && halt_prev) chk("no_req_while_halted", 32'(req), 0);
      if (redirect) begin
         chk("no_req_on_redirect", 32'(req), 0);
         exp_pc = redirect_pc & ~32'h3;
      end else if (valid && ready) begin
         chk("pop_pc", ipc, exp_pc);
         chk("pop_insn", insn, is_fault(exp_pc) ? 32'h0 : img(exp_pc));
         chk("pop_err", 32'(ierr), 32'(is_fault(exp_pc)));
         if (ierr) err_pops++;
         last_pop_pc = ipc;
         exp_pc += 32'h4;
         npop++;
      end
      halt_prev = halt;
   endtask

   task automatic advance();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic tick();
      drive_sample();
      advance();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; halt = 0; redirect = 0; redirect_pc = 0; ready = 1;
      gnt = 0; rvalid = 0; err = 0; rdata = 0;
      #1;
      chk("rst_req", 32'(req), 0);
      chk("rst_addr", addr, 32'h0);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_insn", insn, 32'h0);
      chk("rst_pc", ipc, 32'h0);
      chk("rst_err", 32'(ierr), 0);
      mq.delete();
      exp_pc = 0; halt_prev = 0; got_req = 0; npop = 0; err_pops = 0; ngrant = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc = 0;
   endtask

   task automatic wait_pops(input int n, input int limit);
      int start = npop;
      int k = 0;
      while (npop < start + n && k < limit) begin tick(); k++; end
      chk("wait_pops_in_time", 32'(npop - start >= n), 1);
   endtask

   initial begin
      rst_n = 1'b1; gnt_pct = 100; lat_lo = 1; lat_hi = 1; fault_mode = 0; cyc = 0;
      #2;

      // stall then release with zero-wait memory: rows are cycles after reset release
      tbl[0]  = '{0, 0, 32'h00, 0, 32'h0};
      tbl[1]  = '{0, 1, 32'h00, 0, 32'h0};
      tbl[2]  = '{0, 1, 32'h04, 0, 32'h0};
      tbl[3]  = '{0, 1, 32'h08, 1, 32'h0};
      tbl[4]  = '{0, 1, 32'h0C, 1, 32'h0};
      for (int i = 5; i < 10; i++) tbl[i] = '{0, 0, 32'h10, 1, 32'h0};
      tbl[10] = '{1, 0, 32'h10, 1, 32'h0};
      tbl[11] = '{1, 1, 32'h10, 1, 32'h4};
      tbl[12] = '{1, 1, 32'h14, 1, 32'h8};
      tbl[13] = '{1, 1, 32'h18, 1, 32'hC};
      tbl[14] = '{1, 1, 32'h1C, 1, 32'h10};
      do_reset();
      for (int i = 0; i < 15; i++) begin
         ready = tbl[i].rdy;
         drive_sample();
         chk($sformatf("tbl%0d_req", i), 32'(req), 32'(tbl[i].req));
         chk($sformatf("tbl%0d_addr", i), addr, tbl[i].addr);
         chk($sformatf("tbl%0d_valid", i), 32'(valid), 32'(tbl[i].v));
         if (tbl[i].v) chk($sformatf("tbl%0d_pc", i), ipc, tbl[i].pc);
         if (i < 10 && req && gnt) ngrant++;
         advance();
      end
      chk("grants_while_stalled", ngrant, 4);

      // sustained 1 insn/cycle from cycle 3
      do_reset();
      for (int c = 0; c < 16; c++) begin
         drive_sample();
         chk("sustained_valid", 32'(valid), 32'(c >= 3));
         advance();
      end

      // redirect with two outstanding and a response in the redirect cycle
      do_reset();
      lat_lo = 2; lat_hi = 2;
      tick(); tick(); tick();
      redirect = 1; redirect_pc = 32'h103;
      tick();
      redirect = 0;
      drive_sample();
      chk("redir_first_req", 32'(req), 1);
      chk("redir_first_addr", addr, 32'h100);
      advance();
      wait_pops(1, 20);
      chk("redir_first_pop", last_pop_pc, 32'h100);
      wait_pops(1, 20);
      chk("redir_second_pop", last_pop_pc, 32'h104);

      // access fault on 0x8 is delivered and fetching continues
      do_reset();
      lat_lo = 1; lat_hi = 1; fault_mode = 1;
      wait_pops(5, 40);
      chk("fault_pops", err_pops, 1);
      fault_mode = 0;

      // halt, redirect while halted, release
      do_reset();
      halt = 1;
      repeat (6) tick();
      redirect = 1; redirect_pc = 32'h200;
      tick();
      redirect = 0;
      repeat (3) tick();
      chk("halt_no_req", 32'(got_req), 0);
      halt = 0;
      for (int k = 0; k < 10 && !got_req; k++) tick();
      chk("halt_release_req", 32'(got_req), 1);
      chk("halt_release_addr", first_req_addr, 32'h200);
      wait_pops(2, 20);

      // fetch PC wraps past the top of the address space
      redirect = 1; redirect_pc = 32'hFFFF_FFFE;
      tick();
      redirect = 0;
      wait_pops(1, 20);
      chk("wrap_first", last_pop_pc, 32'hFFFF_FFFC);
      wait_pops(1, 20);
      chk("wrap_second", last_pop_pc, 32'h0);

      // 50% grant, latency 3
      do_reset();
      gnt_pct = 50; lat_lo = 3; lat_hi = 3;
      for (int k = 0; k < 300; k++) begin
         ready = ($urandom_range(3) != 0);
         tick();
      end
      chk("lat3_progress", 32'(npop > 50), 1);

      // fully random traffic, resets applied mid-operation
      for (int r = 0; r < 3; r++) begin
         do_reset();
         gnt_pct = 60; lat_lo = 1; lat_hi = 4; fault_mode = 2;
         for (int k = 0; k < 1000; k++) begin
            ready    = ($urandom_range(9) < 7);
            redirect = ($urandom_range(99) < 3);
            redirect_pc = $urandom;
            if ($urandom_range(99) < 3) halt = ~halt;
            tick();
         end
         redirect = 0;
         chk("random_progress", 32'(npop > 100), 1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
